// File: rtl/status_flags.sv
// 6502 processor status register (P).
// Holds C, Z, I, D, V and N. Updates come from the ALU's registered result,
// from explicit set/clear instructions and from PLP. The block also builds the
// PHP/BRK push image and evaluates branch conditions for the sequencer.
module status_flags #(
    parameter logic RESET_I = 1'b1,
    parameter logic RESET_D = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] alu_result,
    input  logic       alu_carry,
    input  logic       alu_overflow,
    input  logic       upd_valid,
    input  logic [3:0] upd_mask,
    input  logic       bit_mode,
    input  logic [7:0] bit_operand,
    input  logic [2:0] flag_op,
    input  logic       plp_load,
    input  logic [7:0] plp_data,
    input  logic       php_brk,
    input  logic       branch_eval,
    input  logic [2:0] branch_cond,
    output logic       flag_c,
    output logic       flag_z,
    output logic       flag_i,
    output logic       flag_d,
    output logic       flag_v,
    output logic       flag_n,
    output logic [7:0] status_out,
    output logic       branch_taken,
    output logic       branch_valid
);

    // flag_op encodings
    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_CLC  = 3'd1;
    localparam logic [2:0] OP_SEC  = 3'd2;
    localparam logic [2:0] OP_CLI  = 3'd3;
    localparam logic [2:0] OP_SEI  = 3'd4;
    localparam logic [2:0] OP_CLV  = 3'd5;
    localparam logic [2:0] OP_CLD  = 3'd6;
    localparam logic [2:0] OP_SED  = 3'd7;

    // Flag registers
    logic r_c;
    logic r_z;
    logic r_i;
    logic r_d;
    logic r_v;
    logic r_n;
    logic r_branch_taken;
    logic r_branch_valid;

    // Next-state values
    logic w_c_next;
    logic w_z_next;
    logic w_i_next;
    logic w_d_next;
    logic w_v_next;
    logic w_n_next;

    // ALU-side candidate values and enables
    logic w_alu_zero;
    logic w_alu_c_en;
    logic w_alu_z_en;
    logic w_alu_v_en;
    logic w_alu_n_en;
    logic w_alu_v_val;
    logic w_alu_n_val;

    // Branch condition
    logic w_branch_flag;
    logic w_branch_result;

    // ALU/BIT update: per-flag enables and source selection. In BIT mode N and
    // V come straight from the memory operand and C is never touched.
    always_comb begin
        w_alu_zero  = (alu_result == 8'h00);
        w_alu_c_en  = upd_valid && upd_mask[0] && !bit_mode;
        w_alu_z_en  = upd_valid && upd_mask[1];
        w_alu_v_en  = upd_valid && upd_mask[2];
        w_alu_n_en  = upd_valid && upd_mask[3];
        w_alu_v_val = bit_mode ? bit_operand[6] : alu_overflow;
        w_alu_n_val = bit_mode ? bit_operand[7] : alu_result[7];
    end

    // Per-flag next state with priority PLP > flag_op > ALU, so an explicit
    // flag instruction and an ALU update on different flags both land.
    always_comb begin
        w_c_next = r_c;
        w_z_next = r_z;
        w_i_next = r_i;
        w_d_next = r_d;
        w_v_next = r_v;
        w_n_next = r_n;

        // Lowest priority: ALU / BIT results
        if (w_alu_c_en) w_c_next = alu_carry;
        if (w_alu_z_en) w_z_next = w_alu_zero;
        if (w_alu_v_en) w_v_next = w_alu_v_val;
        if (w_alu_n_en) w_n_next = w_alu_n_val;

        // Explicit set/clear instructions override the ALU on their own flag
        case (flag_op)
            OP_CLC:  w_c_next = 1'b0;
            OP_SEC:  w_c_next = 1'b1;
            OP_CLI:  w_i_next = 1'b0;
            OP_SEI:  w_i_next = 1'b1;
            OP_CLV:  w_v_next = 1'b0;
            OP_CLD:  w_d_next = 1'b0;
            OP_SED:  w_d_next = 1'b1;
            OP_NONE: ;
            default: ;
        endcase

        // PLP rewrites every held flag; bits 5 and 4 have no storage
        if (plp_load) begin
            w_n_next = plp_data[7];
            w_v_next = plp_data[6];
            w_d_next = plp_data[3];
            w_i_next = plp_data[2];
            w_z_next = plp_data[1];
            w_c_next = plp_data[0];
        end
    end

    // Branch condition from the flags as they stand now, before any
    // same-cycle update: cond[2:1] picks the flag, cond[0] the tested polarity.
    always_comb begin
        case (branch_cond[2:1])
            2'b00:   w_branch_flag = r_n;
            2'b01:   w_branch_flag = r_v;
            2'b10:   w_branch_flag = r_c;
            default: w_branch_flag = r_z;
        endcase
        w_branch_result = (w_branch_flag == branch_cond[0]);
    end

    // Flag state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_c <= 1'b0;
            r_z <= 1'b0;
            r_i <= RESET_I;
            r_d <= RESET_D;
            r_v <= 1'b0;
            r_n <= 1'b0;
        end else begin
            r_c <= w_c_next;
            r_z <= w_z_next;
            r_i <= w_i_next;
            r_d <= w_d_next;
            r_v <= w_v_next;
            r_n <= w_n_next;
        end
    end

    // Branch result registers: valid pulses per evaluation, taken holds
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_branch_taken <= 1'b0;
            r_branch_valid <= 1'b0;
        end else begin
            r_branch_valid <= branch_eval;
            if (branch_eval) begin
                r_branch_taken <= w_branch_result;
            end
        end
    end

    assign flag_c       = r_c;
    assign flag_z       = r_z;
    assign flag_i       = r_i;
    assign flag_d       = r_d;
    assign flag_v       = r_v;
    assign flag_n       = r_n;
    assign branch_taken = r_branch_taken;
    assign branch_valid = r_branch_valid;

    // Push image: bit 5 is hard-wired high, bit 4 is the B value being pushed
    assign status_out = {r_n, r_v, 1'b1, php_brk, r_d, r_i, r_z, r_c};

endmodule

// File: tb/tb_status_flags.sv
// Directed testbench for status_flags: each task drives one scenario and
// checks its hand-computed expectations inline.
module tb_status_flags;

    logic       clk;
    logic       reset;
    logic [7:0] alu_result;
    logic       alu_carry;
    logic       alu_overflow;
    logic       upd_valid;
    logic [3:0] upd_mask;
    logic       bit_mode;
    logic [7:0] bit_operand;
    logic [2:0] flag_op;
    logic       plp_load;
    logic [7:0] plp_data;
    logic       php_brk;
    logic       branch_eval;
    logic [2:0] branch_cond;
    logic       flag_c, flag_z, flag_i, flag_d, flag_v, flag_n;
    logic [7:0] status_out;
    logic       branch_taken;
    logic       branch_valid;

    int n_checks;
    int n_fail;

    status_flags #(.RESET_I(1'b1), .RESET_D(1'b0)) dut (
        .clk          (clk),
        .reset        (reset),
        .alu_result   (alu_result),
        .alu_carry    (alu_carry),
        .alu_overflow (alu_overflow),
        .upd_valid    (upd_valid),
        .upd_mask     (upd_mask),
        .bit_mode     (bit_mode),
        .bit_operand  (bit_operand),
        .flag_op      (flag_op),
        .plp_load     (plp_load),
        .plp_data     (plp_data),
        .php_brk      (php_brk),
        .branch_eval  (branch_eval),
        .branch_cond  (branch_cond),
        .flag_c       (flag_c),
        .flag_z       (flag_z),
        .flag_i       (flag_i),
        .flag_d       (flag_d),
        .flag_v       (flag_v),
        .flag_n       (flag_n),
        .status_out   (status_out),
        .branch_taken (branch_taken),
        .branch_valid (branch_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {N,V,D,I,Z,C} as one vector for compact comparisons
    function automatic logic [5:0] p_now();
        return {flag_n, flag_v, flag_d, flag_i, flag_z, flag_c};
    endfunction

    // Advance one clock; sample and re-drive 1ns after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        upd_valid   = 1'b0;
        upd_mask    = 4'b0000;
        bit_mode    = 1'b0;
        flag_op     = 3'd0;
        plp_load    = 1'b0;
        branch_eval = 1'b0;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        alu_result   = 8'h00;
        alu_carry    = 1'b0;
        alu_overflow = 1'b0;
        bit_operand  = 8'h00;
        plp_data     = 8'h00;
        php_brk      = 1'b0;
        branch_cond  = 3'd0;
        idle_inputs();
        step();
        step();
        n_checks++;
        if (p_now() !== 6'b000100) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected %b", p_now(), 6'b000100);
        end
        n_checks++;
        if (status_out !== 8'h24) begin
            n_fail++;
            $display("FAIL reset_status_brk0: got %h expected 24", status_out);
        end
        php_brk = 1'b1;
        #1;
        n_checks++;
        if (status_out !== 8'h34) begin
            n_fail++;
            $display("FAIL reset_status_brk1: got %h expected 34", status_out);
        end
        php_brk = 1'b0;
        n_checks++;
        if ({branch_taken, branch_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_branch: got %b expected 00", {branch_taken, branch_valid});
        end
        reset = 1'b0;
        step();
        $display("reset: flags=%b status=%h", p_now(), status_out);
    endtask

    task automatic test_alu_update();
        // Inputs presented but not yet clocked: flags must not move
        alu_result   = 8'h80;
        alu_carry    = 1'b1;
        alu_overflow = 1'b1;
        upd_valid    = 1'b1;
        upd_mask     = 4'b1111;
        #1;
        n_checks++;
        if (p_now() !== 6'b000100) begin
            n_fail++;
            $display("FAIL alu_no_comb_path: got %b expected %b", p_now(), 6'b000100);
        end
        step();
        idle_inputs();
        n_checks++;
        if (p_now() !== 6'b110101) begin
            n_fail++;
            $display("FAIL alu_full_mask: got %b expected %b", p_now(), 6'b110101);
        end
        $display("alu 80/c1/v1 mask 1111: flags=%b", p_now());

        alu_result   = 8'h00;
        alu_carry    = 1'b0;
        alu_overflow = 1'b0;
        upd_valid    = 1'b1;
        upd_mask     = 4'b0010;
        step();
        idle_inputs();
        n_checks++;
        if (p_now() !== 6'b110111) begin
            n_fail++;
            $display("FAIL alu_z_only: got %b expected %b", p_now(), 6'b110111);
        end
        $display("alu 00 mask 0010: flags=%b", p_now());
    endtask

    task automatic test_priority();
        // CLC alongside an ALU Z update: different flags, both take effect
        flag_op    = 3'd1;
        alu_result = 8'h01;
        upd_valid  = 1'b1;
        upd_mask   = 4'b0010;
        step();
        idle_inputs();
        n_checks++;
        if (p_now() !== 6'b110100) begin
            n_fail++;
            $display("FAIL clc_plus_alu_z: got %b expected %b", p_now(), 6'b110100);
        end
        // SEC beats ALU carry 0; ALU still sets Z
        flag_op    = 3'd2;
        alu_result = 8'h00;
        alu_carry  = 1'b0;
        upd_valid  = 1'b1;
        upd_mask   = 4'b0011;
        step();
        idle_inputs();
        n_checks++;
        if (p_now() !== 6'b110111) begin
            n_fail++;
            $display("FAIL sec_over_alu: got %b expected %b", p_now(), 6'b110111);
        end
        $display("sec+alu: flags=%b", p_now());
        // PLP beats CLC
        plp_load = 1'b1;
        plp_data = 8'hC3;
        flag_op  = 3'd1;
        step();
        idle_inputs();
        n_checks++;
        if (p_now() !== 6'b110011) begin
            n_fail++;
            $display("FAIL plp_over_clc: got %b expected %b", p_now(), 6'b110011);
        end
        $display("plp C3 + clc: flags=%b", p_now());
    endtask

    task automatic test_bit();
        // C is 1 here; BIT with mask[0] set and alu_carry 0 must leave it
        bit_mode     = 1'b1;
        bit_operand  = 8'h40;
        alu_result   = 8'h00;
        alu_carry    = 1'b0;
        alu_overflow = 1'b0;
        upd_valid    = 1'b1;
        upd_mask     = 4'b1111;
        step();
        idle_inputs();
        n_checks++;
        if (p_now() !== 6'b010011) begin
            n_fail++;
            $display("FAIL bit_op40: got %b expected %b", p_now(), 6'b010011);
        end
        $display("bit 40: flags=%b", p_now());
    endtask

    task automatic test_branch();
        logic [7:0] exp_taken;
        exp_taken = 8'b01100110; // bit k = expected for code k
        plp_load = 1'b1;
        plp_data = 8'h81;
        step();
        idle_inputs();
        n_checks++;
        if (p_now() !== 6'b100001) begin
            n_fail++;
            $display("FAIL branch_setup: got %b expected %b", p_now(), 6'b100001);
        end
        for (int k = 0; k < 8; k++) begin
            branch_eval = 1'b1;
            branch_cond = 3'(k);
            step();
            branch_eval = 1'b0;
            n_checks++;
            if ({branch_valid, branch_taken} !== {1'b1, exp_taken[k]}) begin
                n_fail++;
                $display("FAIL branch_code%0d: got v=%b t=%b expected v=1 t=%b",
                         k, branch_valid, branch_taken, exp_taken[k]);
            end
            $display("branch code %0d: valid=%b taken=%b", k, branch_valid, branch_taken);
            step();
            n_checks++;
            if ({branch_valid, branch_taken} !== {1'b0, exp_taken[k]}) begin
                n_fail++;
                $display("FAIL branch_hold%0d: got v=%b t=%b expected v=0 t=%b",
                         k, branch_valid, branch_taken, exp_taken[k]);
            end
        end
        // BCS with a same-cycle ALU clear of C: uses the pre-update C
        branch_eval = 1'b1;
        branch_cond = 3'd5;
        alu_carry   = 1'b0;
        upd_valid   = 1'b1;
        upd_mask    = 4'b0001;
        step();
        idle_inputs();
        n_checks++;
        if ({branch_taken, flag_c} !== 2'b10) begin
            n_fail++;
            $display("FAIL bcs_pre_update: got t=%b c=%b expected t=1 c=0", branch_taken, flag_c);
        end
        $display("bcs + clear c: taken=%b c=%b", branch_taken, flag_c);
        // Back-to-back evaluation: BCS now sees C=0, then BMI sees N=1
        branch_eval = 1'b1;
        branch_cond = 3'd5;
        step();
        n_checks++;
        if ({branch_valid, branch_taken} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_first: got v=%b t=%b expected v=1 t=0", branch_valid, branch_taken);
        end
        branch_cond = 3'd1;
        step();
        branch_eval = 1'b0;
        n_checks++;
        if ({branch_valid, branch_taken} !== 2'b11) begin
            n_fail++;
            $display("FAIL b2b_second: got v=%b t=%b expected v=1 t=1", branch_valid, branch_taken);
        end
        $display("back-to-back: valid=%b taken=%b", branch_valid, branch_taken);
        step();
    endtask

    task automatic test_flag_ops();
        logic [2:0] ops [8];
        logic [5:0] exp [8];
        ops = '{3'd2, 3'd4, 3'd7, 3'd5, 3'd1, 3'd3, 3'd6, 3'd0};
        exp = '{6'b010011, 6'b010111, 6'b011111, 6'b001111,
                6'b001110, 6'b001010, 6'b000010, 6'b000010};
        plp_load = 1'b1;
        plp_data = 8'h42;
        step();
        idle_inputs();
        for (int k = 0; k < 8; k++) begin
            flag_op = ops[k];
            step();
            flag_op = 3'd0;
            n_checks++;
            if (p_now() !== exp[k]) begin
                n_fail++;
                $display("FAIL flag_op%0d: got %b expected %b", ops[k], p_now(), exp[k]);
            end
            $display("flag_op %0d: flags=%b", ops[k], p_now());
        end
    endtask

    task automatic test_async_reset();
        flag_op = 3'd2; // SEC so C differs from reset
        step();
        flag_op = 3'd0;
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (p_now() !== 6'b000100) begin
            n_fail++;
            $display("FAIL async_reset: got %b expected %b", p_now(), 6'b000100);
        end
        $display("async reset mid-cycle: flags=%b", p_now());
        // Reset held across a pending update discards it
        alu_result = 8'h80;
        alu_carry  = 1'b1;
        upd_valid  = 1'b1;
        upd_mask   = 4'b1111;
        step();
        idle_inputs();
        reset = 1'b0;
        n_checks++;
        if (p_now() !== 6'b000100) begin
            n_fail++;
            $display("FAIL reset_discards_update: got %b expected %b", p_now(), 6'b000100);
        end
        step();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_alu_update();
        test_priority();
        test_bit();
        test_branch();
        test_flag_ops();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
